// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and the RV32I datapath.
// The controller (master) reads the IR and drives every enable and mux select.
interface multicycle_ctrl_if;
    logic [31:0] instr;
    logic        pc_write;
    logic        ir_write;
    logic        mem_write;
    logic        reg_write;
    logic        mdr_write;
    logic [2:0]  imm_ctrl;
    logic [3:0]  alu_ctrl;
    logic        alu_in2_ctrl;
    logic        addrsrc_ctrl;
    logic        regwrite_ctrl;
    logic        trap;
    logic [3:0]  state_dbg;

    modport master (
        input  instr,
        output pc_write, ir_write, mem_write, reg_write, mdr_write,
        output imm_ctrl, alu_ctrl, alu_in2_ctrl, addrsrc_ctrl, regwrite_ctrl,
        output trap, state_dbg
    );

    modport slave (
        output instr,
        input  pc_write, ir_write, mem_write, reg_write, mdr_write,
        input  imm_ctrl, alu_ctrl, alu_in2_ctrl, addrsrc_ctrl, regwrite_ctrl,
        input  trap, state_dbg
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore control FSM sequencing the multicycle RV32I datapath.
// Supports R/I-ALU, LW, SW, LUI, FENCE (NOP); ECALL/EBREAK/illegal trap.
// MEM_WAIT adds wait cycles to FETCH, MEMRD and MEMWR.
module multicycle_ctrl #(
    parameter int MEM_WAIT        = 0,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input logic              clk,
    input logic              rst,
    multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_TRAP   = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_IALU, C_LUI, C_LW, C_SW, C_FENCE, C_SYS, C_ILL
    } iclass_t;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_U = 3'b011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;
    localparam logic [3:0] ALU_PASS = 4'b1010;

    state_t     state, state_nxt;
    logic [3:0] wait_cnt;
    logic       wait_done;
    iclass_t    iclass;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       bit30;
    logic       unused_bits;

    assign opcode      = bus.instr[6:0];
    assign funct3      = bus.instr[14:12];
    assign bit30       = bus.instr[30];
    assign unused_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};
    assign wait_done   = (wait_cnt == WAIT_LAST);

    // funct3 -> ALU op; SUB only for R-type with bit30, SRA for either form
    function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic b30,
                                           input logic is_r);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_r && b30) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = b30 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Classify the opcode held in the IR
    always_comb begin
        case (opcode)
            7'b0110011: iclass = C_R;
            7'b0010011: iclass = C_IALU;
            7'b0110111: iclass = C_LUI;
            7'b0000011: iclass = C_LW;
            7'b0100011: iclass = C_SW;
            7'b0001111: iclass = C_FENCE;
            7'b1110011: iclass = C_SYS;
            default:    iclass = C_ILL;
        endcase
    end

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    // Wait counter: clears on every state change, saturates at MEM_WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     wait_cnt <= 4'd0;
        else if (state_nxt != state) wait_cnt <= 4'd0;
        else if (!wait_done)         wait_cnt <= wait_cnt + 4'd1;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (wait_done) state_nxt = S_DECODE;
            S_DECODE: begin
                case (iclass)
                    C_R, C_IALU, C_LUI: state_nxt = S_EXEC;
                    C_LW, C_SW:         state_nxt = S_MEMADR;
                    C_FENCE:            state_nxt = S_FETCH;
                    C_SYS:              state_nxt = S_TRAP;
                    default:            state_nxt = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (iclass == C_LW)      state_nxt = S_MEMRD;
                else if (iclass == C_SW) state_nxt = S_MEMWR;
                else                     state_nxt = S_FETCH;
            end
            S_MEMRD:  if (wait_done) state_nxt = S_MEMWB;
            S_MEMWB:  state_nxt = S_FETCH;
            S_MEMWR:  if (wait_done) state_nxt = S_FETCH;
            S_EXEC:   state_nxt = S_ALUWB;
            S_ALUWB:  state_nxt = S_FETCH;
            S_TRAP:   state_nxt = S_TRAP;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // Moore outputs; forced quiet while rst is held so no partial write escapes
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.reg_write     = 1'b0;
        bus.mdr_write     = 1'b0;
        bus.imm_ctrl      = IMM_I;
        bus.alu_ctrl      = ALU_ADD;
        bus.alu_in2_ctrl  = 1'b0;
        bus.addrsrc_ctrl  = 1'b0;
        bus.regwrite_ctrl = 1'b0;
        bus.trap          = 1'b0;
        bus.state_dbg     = rst ? 4'd0 : state;
        if (!rst) begin
            // ALU setup is shared by DECODE and the states that hold its result
            if (state == S_DECODE || state == S_EXEC || state == S_ALUWB) begin
                case (iclass)
                    C_R: bus.alu_ctrl = alu_map(funct3, bit30, 1'b1);
                    C_IALU: begin
                        bus.alu_ctrl     = alu_map(funct3, bit30, 1'b0);
                        bus.alu_in2_ctrl = 1'b1;
                    end
                    C_LUI: begin
                        bus.imm_ctrl     = IMM_U;
                        bus.alu_ctrl     = ALU_PASS;
                        bus.alu_in2_ctrl = 1'b1;
                    end
                    default: ;
                endcase
            end
            if ((state == S_DECODE || state == S_MEMADR || state == S_MEMRD ||
                 state == S_MEMWR || state == S_MEMWB) &&
                (iclass == C_LW || iclass == C_SW)) begin
                bus.alu_ctrl     = ALU_ADD;
                bus.alu_in2_ctrl = 1'b1;
                bus.imm_ctrl     = (iclass == C_SW) ? IMM_S : IMM_I;
            end
            case (state)
                S_FETCH: begin
                    bus.pc_write = wait_done;
                    bus.ir_write = wait_done;
                end
                S_MEMRD: begin
                    bus.addrsrc_ctrl = 1'b1;
                    bus.mdr_write    = wait_done;
                end
                S_MEMWR: begin
                    bus.addrsrc_ctrl = 1'b1;
                    bus.mem_write    = wait_done;
                end
                S_MEMWB: begin
                    bus.reg_write     = 1'b1;
                    bus.regwrite_ctrl = 1'b1;
                end
                S_ALUWB: bus.reg_write = 1'b1;
                S_TRAP:  bus.trap = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: three instances cover MEM_WAIT=0,
// MEM_WAIT=3 and TRAP_ON_ILLEGAL=0; every cycle's outputs are compared
// against hand-computed vectors.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_if if0 ();
    multicycle_ctrl_if if3 ();
    multicycle_ctrl_if ifn ();

    multicycle_ctrl #(.MEM_WAIT(0), .TRAP_ON_ILLEGAL(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(if0.master));
    multicycle_ctrl #(.MEM_WAIT(3), .TRAP_ON_ILLEGAL(1'b1)) dut3 (.clk(clk), .rst(rst), .bus(if3.master));
    multicycle_ctrl #(.MEM_WAIT(0), .TRAP_ON_ILLEGAL(1'b0)) dutn (.clk(clk), .rst(rst), .bus(ifn.master));

    // {state, trap, pc_w, ir_w, mem_w, reg_w, mdr_w, imm, alu, in2, addrsrc, regwrite_ctrl}
    logic [19:0] o0, o3, on;
    assign o0 = {if0.state_dbg, if0.trap, if0.pc_write, if0.ir_write, if0.mem_write, if0.reg_write,
                 if0.mdr_write, if0.imm_ctrl, if0.alu_ctrl, if0.alu_in2_ctrl, if0.addrsrc_ctrl, if0.regwrite_ctrl};
    assign o3 = {if3.state_dbg, if3.trap, if3.pc_write, if3.ir_write, if3.mem_write, if3.reg_write,
                 if3.mdr_write, if3.imm_ctrl, if3.alu_ctrl, if3.alu_in2_ctrl, if3.addrsrc_ctrl, if3.regwrite_ctrl};
    assign on = {ifn.state_dbg, ifn.trap, ifn.pc_write, ifn.ir_write, ifn.mem_write, ifn.reg_write,
                 ifn.mdr_write, ifn.imm_ctrl, ifn.alu_ctrl, ifn.alu_in2_ctrl, ifn.addrsrc_ctrl, ifn.regwrite_ctrl};

    // enable groups {trap, pc_w, ir_w, mem_w, reg_w, mdr_w}
    localparam logic [5:0] E_NONE  = 6'b000000;
    localparam logic [5:0] E_FETCH = 6'b011000;
    localparam logic [5:0] E_MW    = 6'b000100;
    localparam logic [5:0] E_RW    = 6'b000010;
    localparam logic [5:0] E_MDR   = 6'b000001;
    localparam logic [5:0] E_TRAP  = 6'b100000;

    localparam logic [31:0] I_SW    = 32'h0020A423;
    localparam logic [31:0] I_LW    = 32'h0080A183;
    localparam logic [31:0] I_ADD   = 32'h00208233;
    localparam logic [31:0] I_SUB   = 32'h40208233;
    localparam logic [31:0] I_SRAI  = 32'h4030D313;
    localparam logic [31:0] I_LUI   = 32'h123452B7;
    localparam logic [31:0] I_ADDIN = 32'hC0000093;
    localparam logic [31:0] I_FENCE = 32'h0000000F;
    localparam logic [31:0] I_ECALL = 32'h00000073;
    localparam logic [31:0] I_ILL   = 32'hFFFFFFFF;
    localparam logic [31:0] I_NOP   = 32'h00000013;

    function automatic logic [19:0] ev(input logic [3:0] st, input logic [5:0] en,
                                       input logic [2:0] imm, input logic [3:0] alu,
                                       input logic in2, input logic addr, input logic rwc);
        return {st, en, imm, alu, in2, addr, rwc};
    endfunction

    task automatic cmp(input logic [19:0] obs, input logic [19:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%05h expected=%05h", tag, obs, exp);
        end
    endtask

    // Wait to the next falling edge and check the selected instance
    task automatic cyc(input int d, input logic [19:0] exp, input string tag);
        @(negedge clk);
        if (d == 0)      cmp(o0, exp, tag);
        else if (d == 1) cmp(o3, exp, tag);
        else             cmp(on, exp, tag);
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        if0.instr = I_SW;
        if3.instr = I_NOP;
        ifn.instr = I_NOP;

        // Reset: everything quiet, state FETCH
        cyc(0, ev(0, E_NONE, 3'b000, 4'h0, 0, 0, 0), "rst0");
        cyc(1, ev(0, E_NONE, 3'b000, 4'h0, 0, 0, 0), "rst3");
        release_rst();

        // SW x2,8(x1), MEM_WAIT=0: 0,1,2,5,0
        cyc(0, ev(0, E_FETCH, 3'b000, 4'h0, 0, 0, 0), "sw_fetch");
        cyc(0, ev(1, E_NONE,  3'b001, 4'h0, 1, 0, 0), "sw_decode");
        cyc(0, ev(2, E_NONE,  3'b001, 4'h0, 1, 0, 0), "sw_memadr");
        cyc(0, ev(5, E_MW,    3'b001, 4'h0, 1, 1, 0), "sw_memwr");
        cyc(0, ev(0, E_FETCH, 3'b000, 4'h0, 0, 0, 0), "sw_fetch2");
        if0.instr = I_LW;

        // LW x3,8(x1): 1,2,3,4,0
        cyc(0, ev(1, E_NONE,  3'b000, 4'h0, 1, 0, 0), "lw_decode");
        cyc(0, ev(2, E_NONE,  3'b000, 4'h0, 1, 0, 0), "lw_memadr");
        cyc(0, ev(3, E_MDR,   3'b000, 4'h0, 1, 1, 0), "lw_memrd");
        cyc(0, ev(4, E_RW,    3'b000, 4'h0, 1, 0, 1), "lw_memwb");
        cyc(0, ev(0, E_FETCH, 3'b000, 4'h0, 0, 0, 0), "lw_fetch");
        if0.instr = I_ADD;

        // ADD
        cyc(0, ev(1, E_NONE,  3'b000, 4'h0, 0, 0, 0), "add_decode");
        cyc(0, ev(6, E_NONE,  3'b000, 4'h0, 0, 0, 0), "add_exec");
        cyc(0, ev(7, E_RW,    3'b000, 4'h0, 0, 0, 0), "add_aluwb");
        cyc(0, ev(0, E_FETCH, 3'b000, 4'h0, 0, 0, 0), "add_fetch");
        if0.instr = I_SUB;

        // SUB
        cyc(0, ev(1, E_NONE,  3'b000, 4'h1, 0, 0, 0), "sub_decode");
        cyc(0, ev(6, E_NONE,  3'b000, 4'h1, 0, 0, 0), "sub_exec");
        cyc(0, ev(7, E_RW,    3'b000, 4'h1, 0, 0, 0), "sub_aluwb");
        cyc(0, ev(0, E_FETCH, 3'b000, 4'h0, 0, 0, 0), "sub_fetch");
        if0.instr = I_SRAI;

        // SRAI x6,x1,3
        cyc(0, ev(1, E_NONE,  3'b000, 4'h7, 1, 0, 0), "srai_decode");
        cyc(0, ev(6, E_NONE,  3'b000, 4'h7, 1, 0, 0), "srai_exec");
        cyc(0, ev(7, E_RW,    3'b000, 4'h7, 1, 0, 0), "srai_aluwb");
        cyc(0, ev(0, E_FETCH, 3'b000, 4'h0, 0, 0, 0), "srai_fetch");
        if0.instr = I_LUI;

        // LUI x5,0x12345
        cyc(0, ev(1, E_NONE,  3'b011, 4'hA, 1, 0, 0), "lui_decode");
        cyc(0, ev(6, E_NONE,  3'b011, 4'hA, 1, 0, 0), "lui_exec");
        cyc(0, ev(7, E_RW,    3'b011, 4'hA, 1, 0, 0), "lui_aluwb");
        cyc(0, ev(0, E_FETCH, 3'b000, 4'h0, 0, 0, 0), "lui_fetch");
        if0.instr = I_ADDIN;

        // ADDI with instr[30]=1 must stay ADD
        cyc(0, ev(1, E_NONE,  3'b000, 4'h0, 1, 0, 0), "addi_decode");
        cyc(0, ev(6, E_NONE,  3'b000, 4'h0, 1, 0, 0), "addi_exec");
        cyc(0, ev(7, E_RW,    3'b000, 4'h0, 1, 0, 0), "addi_aluwb");
        cyc(0, ev(0, E_FETCH, 3'b000, 4'h0, 0, 0, 0), "addi_fetch");
        if0.instr = I_FENCE;

        // FENCE: two cycles
        cyc(0, ev(1, E_NONE,  3'b000, 4'h0, 0, 0, 0), "fence_decode");
        cyc(0, ev(0, E_FETCH, 3'b000, 4'h0, 0, 0, 0), "fence_fetch");
        if0.instr = I_ILL;

        // Illegal opcode traps and stays trapped
        cyc(0, ev(1, E_NONE,  3'b000, 4'h0, 0, 0, 0), "ill_decode");
        cyc(0, ev(8, E_TRAP,  3'b000, 4'h0, 0, 0, 0), "ill_trap");
        cyc(0, ev(8, E_TRAP,  3'b000, 4'h0, 0, 0, 0), "ill_trap_sticky");

        // MEM_WAIT=3 SW
        rst = 1'b1;
        if3.instr = I_SW;
        cyc(0, ev(0, E_NONE,  3'b000, 4'h0, 0, 0, 0), "trap_cleared_by_rst");
        release_rst();
        cyc(1, ev(0, E_NONE,  3'b000, 4'h0, 0, 0, 0), "w3_fetch0");
        cyc(1, ev(0, E_NONE,  3'b000, 4'h0, 0, 0, 0), "w3_fetch1");
        cyc(1, ev(0, E_NONE,  3'b000, 4'h0, 0, 0, 0), "w3_fetch2");
        cyc(1, ev(0, E_FETCH, 3'b000, 4'h0, 0, 0, 0), "w3_fetch3");
        cyc(1, ev(1, E_NONE,  3'b001, 4'h0, 1, 0, 0), "w3_decode");
        cyc(1, ev(2, E_NONE,  3'b001, 4'h0, 1, 0, 0), "w3_memadr");
        cyc(1, ev(5, E_NONE,  3'b001, 4'h0, 1, 1, 0), "w3_memwr0");
        cyc(1, ev(5, E_NONE,  3'b001, 4'h0, 1, 1, 0), "w3_memwr1");
        cyc(1, ev(5, E_NONE,  3'b001, 4'h0, 1, 1, 0), "w3_memwr2");
        cyc(1, ev(5, E_MW,    3'b001, 4'h0, 1, 1, 0), "w3_memwr3");
        cyc(1, ev(0, E_NONE,  3'b000, 4'h0, 0, 0, 0), "w3_fetch_again");

        // Second SW, reset mid-MEMWR before the strobe
        repeat (3) @(negedge clk);
        cyc(1, ev(1, E_NONE,  3'b001, 4'h0, 1, 0, 0), "rsw_decode");
        cyc(1, ev(2, E_NONE,  3'b001, 4'h0, 1, 0, 0), "rsw_memadr");
        cyc(1, ev(5, E_NONE,  3'b001, 4'h0, 1, 1, 0), "rsw_memwr0");
        cyc(1, ev(5, E_NONE,  3'b001, 4'h0, 1, 1, 0), "rsw_memwr1");
        #1 rst = 1'b1;
        #1 cmp(o3, ev(0, E_NONE, 3'b000, 4'h0, 0, 0, 0), "rsw_async_quiet");
        cyc(1, ev(0, E_NONE,  3'b000, 4'h0, 0, 0, 0), "rsw_held");
        cyc(1, ev(0, E_NONE,  3'b000, 4'h0, 0, 0, 0), "rsw_held2");
        release_rst();
        cyc(1, ev(0, E_NONE,  3'b000, 4'h0, 0, 0, 0), "rsw_resume0");
        cyc(1, ev(0, E_NONE,  3'b000, 4'h0, 0, 0, 0), "rsw_resume1");
        cyc(1, ev(0, E_NONE,  3'b000, 4'h0, 0, 0, 0), "rsw_resume2");
        cyc(1, ev(0, E_FETCH, 3'b000, 4'h0, 0, 0, 0), "rsw_resume3");

        // TRAP_ON_ILLEGAL=0: illegal is a NOP, ECALL still traps
        rst = 1'b1;
        ifn.instr = I_ILL;
        @(negedge clk);
        release_rst();
        cyc(2, ev(0, E_FETCH, 3'b000, 4'h0, 0, 0, 0), "nt_fetch");
        cyc(2, ev(1, E_NONE,  3'b000, 4'h0, 0, 0, 0), "nt_ill_decode");
        cyc(2, ev(0, E_FETCH, 3'b000, 4'h0, 0, 0, 0), "nt_ill_back_to_fetch");
        ifn.instr = I_ECALL;
        cyc(2, ev(1, E_NONE,  3'b000, 4'h0, 0, 0, 0), "nt_ecall_decode");
        cyc(2, ev(8, E_TRAP,  3'b000, 4'h0, 0, 0, 0), "nt_ecall_trap");
        cyc(2, ev(8, E_TRAP,  3'b000, 4'h0, 0, 0, 0), "nt_ecall_sticky");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
